// File: rtl/reg_file_sb.sv
// Integer register file (2 comb reads, 1 write) with a scoreboard that stalls decode on late-value hazards.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_sb #(
  parameter  int XLEN = 64,
  parameter  int NREG = 32,
  localparam int IW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [IW-1:0]   rs1,
  input  logic [IW-1:0]   rs2,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  input  logic            issueValid,
  input  logic            markBusy,
  input  logic [IW-1:0]   rd_D,
  output logic            stall,
  input  logic            regWrite,
  input  logic [IW-1:0]   rd_W,
  input  logic [XLEN-1:0] writeData_R,
  input  logic            flush,
  output logic [NREG-1:0] busyVec,
  output logic [5:0]      busyCount
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [5:0]      cnt_q, cnt_d;

  logic wr_en;
  logic fwd1, fwd2;
  logic haz_s1, haz_s2, haz_d;
  logic accept;

  assign wr_en = regWrite && (rd_W != '0);

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wr_en && (rd_W == rs1);
  assign fwd2 = wr_en && (rd_W == rs2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // x0 is never written after reset, so the array entry itself reads as zero
  assign readData1 = fwd1 ? writeData_R : regs_q[rs1];
  assign readData2 = fwd2 ? writeData_R : regs_q[rs2];

  assign haz_s1 = busy_q[rs1] && (rs1 != '0) && !fwd1;
  assign haz_s2 = busy_q[rs2] && (rs2 != '0) && !fwd2;
  assign haz_d  = markBusy && busy_q[rd_D] && (rd_D != '0);

  assign stall  = issueValid && (haz_s1 || haz_s2 || haz_d);
  assign accept = issueValid && !stall;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en)
        busy_d[rd_W] = 1'b0;
      // a new producer issued this cycle outranks the retiring one
      if (accept && markBusy && (rd_D != '0))
        busy_d[rd_D] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++)
      cnt_d = cnt_d + 6'(busy_d[i]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en)
        regs_q[rd_W] <= writeData_R;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busyVec   = busy_q;
  assign busyCount = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: stimulus pushes expected outputs per cycle, a negedge monitor pops and checks.
module tb_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rs1, rs2, rd_D, rd_W;
  logic [63:0] readData1, readData2, writeData_R;
  logic        issueValid, markBusy, stall, regWrite, flush;
  logic [31:0] busyVec;
  logic [5:0]  busyCount;

  reg_file_sb dut (
    .clk(clk), .resetn(resetn),
    .rs1(rs1), .rs2(rs2),
    .readData1(readData1), .readData2(readData2),
    .issueValid(issueValid), .markBusy(markBusy), .rd_D(rd_D),
    .stall(stall),
    .regWrite(regWrite), .rd_W(rd_W), .writeData_R(writeData_R),
    .flush(flush),
    .busyVec(busyVec), .busyCount(busyCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] rd1;
    logic [63:0] rd2;
    bit          chk_rd;
    logic        stl;
    logic [31:0] busy;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string n, input string f, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got %h want %h", n, f, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_rd) begin
        chk(e.name, "readData1", readData1, e.rd1);
        chk(e.name, "readData2", readData2, e.rd2);
      end
      chk(e.name, "stall", 64'(stall), 64'(e.stl));
      chk(e.name, "busyVec", 64'(busyVec), 64'(e.busy));
      chk(e.name, "busyCount", 64'(busyCount), 64'(e.cnt));
    end
  end

  task automatic ex(input string n, input logic [63:0] r1, input logic [63:0] r2, input bit c,
                    input logic s, input logic [31:0] b, input logic [5:0] k);
    exp_t e;
    e.name = n; e.rd1 = r1; e.rd2 = r2; e.chk_rd = c;
    e.stl = s; e.busy = b; e.cnt = k;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    resetn = 1'b1; issueValid = 1'b0; markBusy = 1'b0; rd_D = '0;
    regWrite = 1'b0; rd_W = '0; writeData_R = '0; flush = 1'b0;
    rs1 = '0; rs2 = '0;
  endtask

  localparam logic [63:0] D5 = 64'hDEAD_BEEF_0000_0001;

  initial begin
    resetn = 1'b0; issueValid = 1'b0; markBusy = 1'b0; rd_D = '0;
    regWrite = 1'b0; rd_W = '0; writeData_R = '0; flush = 1'b0;
    rs1 = '0; rs2 = '0;
    cyc(); resetn = 1'b0;
    cyc(); resetn = 1'b0;

    // every index reads zero after reset
    for (int i = 0; i < 32; i++) begin
      cyc(); issueValid = 1'b1; rs1 = 5'(i); rs2 = 5'(31 - i);
      ex("rst_read", 64'h0, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);
    end

    cyc(); regWrite = 1'b1; rd_W = 5'd5; writeData_R = D5; rs1 = 5'd5;
    ex("wr_x5", BYP ? D5 : 64'h0, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);
    cyc(); regWrite = 1'b1; rd_W = 5'd0; writeData_R = 64'h1234; rs1 = 5'd5; rs2 = 5'd0;
    ex("wr_x0", D5, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);
    cyc(); rs1 = 5'd5; rs2 = 5'd0;
    ex("rd_x5_x0", D5, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);

    // load to x7, then a consumer of x7
    cyc(); issueValid = 1'b1; markBusy = 1'b1; rd_D = 5'd7;
    ex("mark_x7", 64'h0, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);
    cyc(); issueValid = 1'b1; rs1 = 5'd7;
    ex("raw_x7", 64'h0, 64'h0, 1'b1, 1'b1, 32'h80, 6'd1);
    cyc(); issueValid = 1'b1; rs1 = 5'd7; regWrite = 1'b1; rd_W = 5'd7; writeData_R = 64'h42;
    ex("wb_x7", BYP ? 64'h42 : 64'h0, 64'h0, 1'b1, BYP ? 1'b0 : 1'b1, 32'h80, 6'd1);
    cyc(); issueValid = 1'b1; rs1 = 5'd7;
    ex("after_wb_x7", 64'h42, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);

    // set beats clear on x9, then WAW stall
    cyc(); issueValid = 1'b1; markBusy = 1'b1; rd_D = 5'd9; regWrite = 1'b1; rd_W = 5'd9; writeData_R = 64'h99;
    ex("set_clr_x9", 64'h0, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);
    cyc(); issueValid = 1'b1; markBusy = 1'b1; rd_D = 5'd9;
    ex("waw_x9", 64'h0, 64'h0, 1'b1, 1'b1, 32'h200, 6'd1);
    cyc(); rs1 = 5'd9;
    ex("held_x9", 64'h99, 64'h0, 1'b1, 1'b0, 32'h200, 6'd1);
    cyc(); regWrite = 1'b1; rd_W = 5'd9; writeData_R = 64'h100;
    ex("wb_x9", 64'h0, 64'h0, 1'b1, 1'b0, 32'h200, 6'd1);

    // build up three busy entries, then flush alongside a new mark
    cyc(); issueValid = 1'b1; markBusy = 1'b1; rd_D = 5'd3; rs1 = 5'd9;
    ex("mark_x3", 64'h100, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);
    cyc(); issueValid = 1'b1; markBusy = 1'b1; rd_D = 5'd4;
    ex("mark_x4", 64'h0, 64'h0, 1'b1, 1'b0, 32'h8, 6'd1);
    cyc(); issueValid = 1'b1; markBusy = 1'b1; rd_D = 5'd6;
    ex("mark_x6", 64'h0, 64'h0, 1'b1, 1'b0, 32'h18, 6'd2);
    cyc(); issueValid = 1'b1; rs1 = 5'd4; rs2 = 5'd2;
    ex("three_busy", 64'h0, 64'h0, 1'b1, 1'b1, 32'h58, 6'd3);
    cyc(); flush = 1'b1; issueValid = 1'b1; markBusy = 1'b1; rd_D = 5'd10;
    ex("flush", 64'h0, 64'h0, 1'b1, 1'b0, 32'h58, 6'd3);
    cyc(); issueValid = 1'b1; rs1 = 5'd10;
    ex("post_flush", 64'h0, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);

    // reset beats a pending write and a busy bit
    cyc(); issueValid = 1'b1; markBusy = 1'b1; rd_D = 5'd3;
    ex("mark_x3b", 64'h0, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);
    cyc(); resetn = 1'b0; regWrite = 1'b1; rd_W = 5'd3; writeData_R = 64'h3333;
    ex("in_reset", 64'h0, 64'h0, 1'b0, 1'b0, 32'h8, 6'd1);
    cyc(); issueValid = 1'b1; rs1 = 5'd3; rs2 = 5'd5;
    ex("post_reset", 64'h0, 64'h0, 1'b1, 1'b0, 32'h0, 6'd0);

    cyc();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
